aes128_iter_core: RTL

//  Iterative AES-128 encryption engine: one 128-bit block in, ciphertext out, 10 rounds reusing one

---
 rtl/aes128_iter_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor. One round datapath is reused for all 10 rounds, and round keys are expanded on the fly.
// SubBytes runs over SBOX_LANES S-boxes, taking 16/SBOX_LANES cycles per round.
module aes128_iter_core #(
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int         SUB_CYC  = 16 / SBOX_LANES;
    localparam logic [1:0] LAST_GRP = 2'(SUB_CYC - 1);

    generate
        if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
            $error("SBOX_LANES must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_MIX, S_DONE} state_t;

    state_t         r_fsm, w_fsm_nxt;
    logic [127:0]   r_state, r_key, r_out_data;
    logic [7:0]     r_rcon;
    logic [3:0]     r_round;
    logic [1:0]     r_lane_cnt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128), followed by the FIPS affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_mix(input logic [127:0] s, input logic mix);
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r + 4*c] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
            if (mix)
                o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            else
                o[127 - 32*c -: 32] = {a0, a1, a2, a3};
        end
        return o;
    endfunction

    // State S-box lanes: group r_lane_cnt covers bytes r_lane_cnt*SBOX_LANES onward.
    logic [SBOX_LANES-1:0][7:0] w_sbox_in, w_sbox_out;
    logic [127:0]               w_sub_state;

    always_comb begin
        w_sbox_in = '0;
        for (int l = 0; l < SBOX_LANES; l++)
            w_sbox_in[l] = r_state[127 - 8*(int'(r_lane_cnt)*SBOX_LANES + l) -: 8];
    end

    generate
        for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
            assign w_sbox_out[l] = sbox(w_sbox_in[l]);
        end
    endgenerate

    always_comb begin
        w_sub_state = r_state;
        for (int l = 0; l < SBOX_LANES; l++)
            w_sub_state[127 - 8*(int'(r_lane_cnt)*SBOX_LANES + l) -: 8] = w_sbox_out[l];
    end

    // Key schedule step with its own four S-boxes on RotWord(w3).
    logic [31:0]  w_rot, w_ksub, w_temp, w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_key_nxt, w_round_out;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_ksbox
            assign w_ksub[8*k +: 8] = sbox(w_rot[8*k +: 8]);
        end
    endgenerate

    assign w_temp      = w_ksub ^ {r_rcon, 24'h000000};
    assign w_n0        = r_key[127:96] ^ w_temp;
    assign w_n1        = r_key[95:64]  ^ w_n0;
    assign w_n2        = r_key[63:32]  ^ w_n1;
    assign w_n3        = r_key[31:0]   ^ w_n2;
    assign w_key_nxt   = {w_n0, w_n1, w_n2, w_n3};
    assign w_round_out = shift_mix(r_state, r_round != 4'd10) ^ w_key_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (in_valid)                w_fsm_nxt = S_SUB;
            S_SUB:  if (r_lane_cnt == LAST_GRP)  w_fsm_nxt = S_MIX;
            S_MIX:  w_fsm_nxt = (r_round == 4'd10) ? S_DONE : S_SUB;
            S_DONE: if (out_ready)               w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= '0;
            r_key      <= '0;
            r_out_data <= '0;
            r_rcon     <= 8'h01;
            r_round    <= 4'd0;
            r_lane_cnt <= 2'd0;
        end else begin
            case (r_fsm)
                S_IDLE: if (in_valid) begin
                    r_state    <= in_data ^ in_key;
                    r_key      <= in_key;
                    r_round    <= 4'd1;
                    r_rcon     <= 8'h01;
                    r_lane_cnt <= 2'd0;
                end
                S_SUB: begin
                    r_state    <= w_sub_state;
                    r_lane_cnt <= (r_lane_cnt == LAST_GRP) ? 2'd0 : r_lane_cnt + 2'd1;
                end
                S_MIX: begin
                    r_state <= w_round_out;
                    r_key   <= w_key_nxt;
                    r_rcon  <= xtime(r_rcon);
                    if (r_round == 4'd10) r_out_data <= w_round_out;
                    else                  r_round    <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm == S_SUB) || (r_fsm == S_MIX);
    assign out_valid = (r_fsm == S_DONE);
    assign out_data  = r_out_data;

endmodule
